output_port_arbiter: RTL and testbench

Round-robin arbiter and output buffer that drains a leaf's output ports into the single BFT injection link. It sits directly downstream of the per-port output queues. Each cycle it asserts at most one port's `rd_en_sel`. One cycle later it captures that port's `internal_out` packet into a 4-entry buffer, then presents packets to the BFT switch under a valid/ready handshake. Everything runs in the clk(_bft) domain.

---
 rtl/output_port_arbiter.sv | 135 +++++++++++++
 tb/tb_output_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
// Round-robin drain of a leaf's output-port queues into a 4-entry buffer feeding the BFT link.
// Optional stall counter output arb_stall_cnt is built when ARB_STALL_CNT_EN is defined.
module output_port_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_OUT_PORTS = 4,
  parameter int PAYLOAD_BITS  = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_OUT_PORTS-1:0]             empty_vec,
  input  logic [NUM_OUT_PORTS*PACKET_BITS-1:0] internal_out_flat,
  output logic [NUM_OUT_PORTS-1:0]             rd_en_sel_vec,
  output logic [PACKET_BITS-1:0]               dout_leaf_interface2bft,
  input  logic                                 ready_bft2leaf,
  input  logic                                 is_done_mode
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [PAYLOAD_BITS-1:0]              arb_stall_cnt
`endif
);

  localparam int BUF_DEPTH = 4;
  localparam int PTR_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [NUM_OUT_PORTS-1:0] cand;
  logic [PACKET_BITS-1:0]   port_pkt [NUM_OUT_PORTS];
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         pending_idx;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         hi_idx;
  logic [PTR_W-1:0]         lo_idx;
  logic [PTR_W-1:0]         next_rr;
  logic                     hi_found;
  logic                     pending;
  logic                     grant;
  logic [2:0]               count;
  logic [2:0]               occupancy;
  logic [1:0]               wr_ptr;
  logic [1:0]               rd_ptr;
  logic [PACKET_BITS-1:0]   mem [BUF_DEPTH];
  logic [PACKET_BITS-1:0]   captured;
  logic                     push;
  logic                     pop;

  if (NUM_OUT_PORTS < 2) begin : g_bad_ports
    $error("output_port_arbiter needs at least two output ports");
  end

  assign cand = ~empty_vec;

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_unpack
    assign port_pkt[i] = internal_out_flat[i*PACKET_BITS +: PACKET_BITS];
  end

  // Lowest candidate at or above rr_ptr wins; otherwise wrap to the lowest candidate overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_OUT_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // A pop in the same cycle is not credited, so the buffer can never overflow.
  assign occupancy = count + {2'b00, pending};
  assign grant     = !reset && !is_done_mode && (|cand) && (occupancy < 3'(BUF_DEPTH));
  assign next_rr   = (grant_idx == PTR_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  assign rd_en_sel_vec = grant ? (NUM_OUT_PORTS'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      pending     <= 1'b0;
      pending_idx <= '0;
    end else begin
      pending <= grant;
      if (grant) begin
        pending_idx <= grant_idx;
        rr_ptr      <= next_rr;
      end
    end
  end

  // A granted port without credit returns an invalid packet, which is simply dropped.
  assign captured = port_pkt[pending_idx];
  assign push     = pending && captured[PACKET_BITS-1];
  assign pop      = (count != 3'd0) && ready_bft2leaf;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= captured;
  end

  assign dout_leaf_interface2bft = (count != 3'd0) ? mem[rd_ptr] : '0;

`ifdef ARB_STALL_CNT_EN
  // Counts cycles where the switch holds off a waiting packet outside done mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_stall_cnt <= '0;
    end else if ((count != 3'd0) && !ready_bft2leaf && !is_done_mode) begin
      arb_stall_cnt <= arb_stall_cnt + PAYLOAD_BITS'(1);
    end
  end
`else
  if (PAYLOAD_BITS < 1) begin : g_bad_payload
    $error("PAYLOAD_BITS must be positive");
  end
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: queue-based reference model plus directed
// literal checks; stall counter checks are included when ARB_STALL_CNT_EN is defined.
module tb_output_port_arbiter;

  localparam int PACKET_BITS   = 97;
  localparam int NUM_OUT_PORTS = 4;
  localparam int PAYLOAD_BITS  = 64;
  localparam int BUF_DEPTH     = 4;
  localparam int N             = NUM_OUT_PORTS;

  logic                     clk;
  logic                     reset;
  logic [N-1:0]             empty_vec;
  logic [N*PACKET_BITS-1:0] internal_out_flat;
  logic [N-1:0]             rd_en_sel_vec;
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;
  logic                     ready_bft2leaf;
  logic                     is_done_mode;
`ifdef ARB_STALL_CNT_EN
  logic [PAYLOAD_BITS-1:0]  arb_stall_cnt;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] last_rd_en = '0;
  int           port_seq [N];
  logic [N-1:0] no_credit_mask;
  int           credit_pct;

  logic [PACKET_BITS-1:0] mq [$];
  int                     m_rr;
  bit                     m_pending;
  int                     m_pidx;
  bit                     model_valid = 1'b0;
  longint unsigned        m_stall;

  output_port_arbiter #(
    .PACKET_BITS  (PACKET_BITS),
    .NUM_OUT_PORTS(NUM_OUT_PORTS),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .empty_vec              (empty_vec),
    .internal_out_flat      (internal_out_flat),
    .rd_en_sel_vec          (rd_en_sel_vec),
    .dout_leaf_interface2bft(dout_leaf_interface2bft),
    .ready_bft2leaf         (ready_bft2leaf),
    .is_done_mode           (is_done_mode)
`ifdef ARB_STALL_CNT_EN
    ,
    .arb_stall_cnt          (arb_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PACKET_BITS-1:0] makePkt(input bit valid, input int port, input int seq);
    logic [PACKET_BITS-1:0] p;
    p                = '0;
    p[PACKET_BITS-1] = valid;
    p[39:32]         = port[7:0];
    p[31:0]          = seq;
    return p;
  endfunction

  function automatic int pickPort(input int rr, input logic [N-1:0] empties);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (!empties[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [PACKET_BITS-1:0] actual,
                             input logic [PACKET_BITS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] e, input logic rdy, input logic d);
    @(posedge clk);
    #1;
    reset          = r;
    empty_vec      = e;
    ready_bft2leaf = rdy;
    is_done_mode   = d;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, '1, 1'b0, 1'b0);
    applyStimulus(1'b1, '1, 1'b0, 1'b0);
  endtask

  // Output-queue model: a port granted in one cycle presents its next packet in the following cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_rd_en[i]) begin
        bit credit;
        credit = !no_credit_mask[i] && ($urandom_range(99) < credit_pct);
        internal_out_flat[i*PACKET_BITS +: PACKET_BITS] = makePkt(credit, i, port_seq[i]);
        port_seq[i]++;
      end else begin
        internal_out_flat[i*PACKET_BITS +: PACKET_BITS] = '0;
      end
    end
  end

  // Reference model and per-cycle comparison against the DUT.
  always @(negedge clk) begin
    int                     g;
    logic [N-1:0]           exp_rd;
    logic [PACKET_BITS-1:0] exp_dout;
    logic [PACKET_BITS-1:0] pkt;
    last_rd_en = rd_en_sel_vec;
    g          = -1;
    exp_rd     = '0;
    if (!reset && model_valid && !is_done_mode && (mq.size() + int'(m_pending)) < BUF_DEPTH)
      g = pickPort(m_rr, empty_vec);
    if (g >= 0) exp_rd[g] = 1'b1;
    if (reset || model_valid)
      checkOutput("rd_en_sel_vec", PACKET_BITS'(rd_en_sel_vec), PACKET_BITS'(exp_rd));
    if (model_valid) begin
      exp_dout = (mq.size() > 0) ? mq[0] : '0;
      checkOutput("dout", dout_leaf_interface2bft, exp_dout);
      checkOutput("count_bound", PACKET_BITS'(dut.count > 3'd4), '0);
`ifdef ARB_STALL_CNT_EN
      checkOutput("arb_stall_cnt", PACKET_BITS'(arb_stall_cnt), PACKET_BITS'(m_stall));
`endif
    end
    if (reset) begin
      mq.delete();
      m_rr        = 0;
      m_pending   = 1'b0;
      m_pidx      = 0;
      m_stall     = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (mq.size() > 0 && !ready_bft2leaf && !is_done_mode) m_stall++;
      if (mq.size() > 0 && ready_bft2leaf) void'(mq.pop_front());
      if (m_pending) begin
        pkt = internal_out_flat[m_pidx*PACKET_BITS +: PACKET_BITS];
        if (pkt[PACKET_BITS-1]) mq.push_back(pkt);
      end
      m_pending = (g >= 0);
      if (g >= 0) begin
        m_pidx = g;
        m_rr   = (g + 1) % N;
      end
    end
  end

  initial begin
    int           s [N];
    logic [N-1:0] e;
    reset             = 1'b1;
    empty_vec         = '1;
    ready_bft2leaf    = 1'b0;
    is_done_mode      = 1'b0;
    internal_out_flat = '0;
    no_credit_mask    = '0;
    credit_pct        = 100;
    for (int i = 0; i < N; i++) port_seq[i] = 0;

    // Single non-empty port: grant stays on port 1, first packet two cycles after the grant.
    resetDut();
    @(negedge clk);
    checkOutput("reset_rd_en", PACKET_BITS'(rd_en_sel_vec), '0);
    checkOutput("reset_dout", dout_leaf_interface2bft, '0);
    for (int i = 0; i < N; i++) s[i] = port_seq[i];
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 4'b1101, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t1_grant", PACKET_BITS'(rd_en_sel_vec), PACKET_BITS'(4'b0010));
      if (k == 1) checkOutput("t1_dout_empty", dout_leaf_interface2bft, '0);
      if (k >= 2) checkOutput("t1_dout", dout_leaf_interface2bft, makePkt(1'b1, 1, s[1] + k - 2));
    end

    // All ports non-empty: round-robin rotation and gap-free output.
    resetDut();
    for (int i = 0; i < N; i++) s[i] = port_seq[i];
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t2_grant", PACKET_BITS'(rd_en_sel_vec), PACKET_BITS'(4'b0001 << (k % 4)));
      if (k >= 2) checkOutput("t2_dout", dout_leaf_interface2bft, makePkt(1'b1, k - 2, s[k-2]));
    end

    // Backpressure: exactly four grants, head held, release in grant order.
    resetDut();
    for (int i = 0; i < N; i++) s[i] = port_seq[i];
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_grant", PACKET_BITS'(rd_en_sel_vec), (k < 4) ? PACKET_BITS'(4'b0001 << k) : '0);
      if (k >= 2) checkOutput("t3_hold", dout_leaf_interface2bft, makePkt(1'b1, 0, s[0]));
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3_no_credit_for_pop", PACKET_BITS'(rd_en_sel_vec), '0);
    checkOutput("t3_release0", dout_leaf_interface2bft, makePkt(1'b1, 0, s[0]));
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3_resume", PACKET_BITS'(rd_en_sel_vec), PACKET_BITS'(4'b0001));
    checkOutput("t3_release1", dout_leaf_interface2bft, makePkt(1'b1, 1, s[1]));

    // Port 2 without credit: its packet is dropped and the next grant goes to port 3.
    resetDut();
    no_credit_mask = 4'b0100;
    for (int i = 0; i < N; i++) s[i] = port_seq[i];
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
      if (k == 3) checkOutput("t4_next_grant", PACKET_BITS'(rd_en_sel_vec), PACKET_BITS'(4'b1000));
      if (k == 4) checkOutput("t4_dropped", dout_leaf_interface2bft, '0);
      if (k == 5) checkOutput("t4_port3", dout_leaf_interface2bft, makePkt(1'b1, 3, s[3]));
    end
    no_credit_mask = '0;

    // Done mode with two packets in flight, then reset mid-stream.
    resetDut();
    for (int i = 0; i < N; i++) s[i] = port_seq[i];
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_done_no_grant", PACKET_BITS'(rd_en_sel_vec), '0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t5_drain0", dout_leaf_interface2bft, makePkt(1'b1, 0, s[0]));
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t5_drain1", dout_leaf_interface2bft, makePkt(1'b1, 1, s[1]));
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t5_drained", dout_leaf_interface2bft, '0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_reset_rd_en", PACKET_BITS'(rd_en_sel_vec), '0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_reset_dout", dout_leaf_interface2bft, '0);
    checkOutput("t5_reset_rd_en2", PACKET_BITS'(rd_en_sel_vec), '0);

`ifdef ARB_STALL_CNT_EN
    // Ten stalled cycles with data waiting, then the count freezes in done mode.
    resetDut();
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t6_stall_cnt", PACKET_BITS'(arb_stall_cnt), PACKET_BITS'(10));
    end
`endif

    // Randomized traffic against the reference model.
    credit_pct = 85;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) e[i] = ($urandom_range(99) < 40);
      applyStimulus($urandom_range(99) < 2, e, $urandom_range(99) < 70, $urandom_range(99) < 10);
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
